syn_down_cnt: RTL and testbench
===============================

Name: syn_down_cnt

Overview:
- Synchronous load/clear down-counter. It is the decrementing counterpart of the team's up-counter slice chain.
- It covers a full WIDTH-bit word in one block, with a borrow chain, a reload register and a one-shot/periodic run state machine.
- Used for the interval timers and video line/pixel countdowns. The borrow-out cascades into further syn_down_cnt instances.

Parameters:
- WIDTH, 8, counter and reload register width in bits (2..16).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- D  input  WIDTH  parallel load / reload data.
- LDL  input  1  active-low synchronous load of Q from D; enters RUN.
- WRRL  input  1  active-high write of reload register from D.
- CLR  input  1  active-high synchronous clear of Q; enters IDLE.
- BI  input  1  active-high borrow-in (count enable).
- MODE  input  1  0 = one-shot, 1 = periodic auto-reload. Sampled at terminal count.
- Q  output  WIDTH  counter value, registered.
- QB  output  WIDTH  bitwise inverse of Q, registered alongside Q.
- BO  output  1  borrow-out, combinational: BI & RUNNING & (Q == 0).
- TC  output  1  registered one-cycle terminal-count pulse.
- RUNNING  output  1  high in RUN state.

Behaviour:
- Reset, asynchronous, while RESET is high:
  - Q = 0, QB = all ones, reload register = 0.
  - State = IDLE, TC = 0, RUNNING = 0, so BO = 0.
  - Deassertion takes effect at the next CLK edge.
- States:
  - IDLE: counter frozen; BI ignored.
  - RUN: counter decrements when BI = 1.
- Per-edge priority for Q and state, highest first:
  1. LDL = 0: Q <= D; state -> RUN, even if CLR = 1. Load beats clear.
  2. CLR = 1: Q <= 0; state -> IDLE.
  3. RUN, BI = 1, Q != 0: Q <= Q - 1.
  4. RUN, BI = 1, Q == 0 (terminal count):
     - MODE = 1: Q <= reload register; stay RUN.
     - MODE = 0: Q stays 0; state -> IDLE.
  5. Otherwise: Q holds.
- Reload register:
  - WRRL = 1 writes D, independent of the Q priority above.
  - If WRRL and a terminal-count reload happen on the same edge, the old reload value is loaded into Q. The new value applies from the next terminal count.
- TC:
  - Set to 1 on the edge following a terminal-count event (rule 4).
  - Otherwise 0.
  - Load or clear on the terminal edge suppresses the event, so TC = 0.
- QB always equals ~Q; there is no cycle where they disagree.
- Arithmetic: unsigned modulo 2^WIDTH. Q never decrements below 0; wrap happens only by reload.
- LDL = 0 with D = 0:
  - Enters RUN at 0.
  - The next BI = 1 edge is an immediate terminal count.
- Cascade:
  - Higher-order stages connect BI to the lower stage's BO.
  - Q is not required to be contiguous across stages; BO simply gates the next stage.
- Reset mid-count: Q and state return to reset values immediately; a pending TC is lost.
- Latency:
  - Load to Q: 1 edge.
  - Terminal condition to TC: 1 edge.
  - BO: 0 cycles (combinational).

Optional Feature:
- Macro SYNDCNT_SNAPSHOT_EN.
- When defined:
  - Adds input SNAP (1 bit) and output QS (WIDTH).
  - SNAP = 1 captures Q into QS on the rising edge. The captured value is the pre-update Q of that edge.
  - QS resets to 0.
  - QS is unaffected by LDL, CLR and reload.
- When undefined:
  - Neither port exists.
  - No snapshot register is generated.

Test Plan:
- RESET pulse mid-cycle, asynchronous -> Q = 0x00, QB = 0xFF, TC = 0, RUNNING = 0 before the next edge. After release with BI = 1, Q stays 0x00 (IDLE).
- D = 0x03, LDL low 1 cycle, MODE = 0, BI held 1 -> Q = 3, 2, 1, 0 on successive edges.
  - BO = 1 while Q = 0.
  - TC = 1 for exactly one cycle after the next edge.
  - RUNNING drops and Q remains 0.
- Periodic mode: WRRL with D = 0x05, then load D = 0x01, MODE = 1, BI = 1 -> Q = 1, 0, 5, 4, 3, 2, 1, 0, 5. TC pulses after each 0 -> 5 transition; RUNNING stays 1.
- LDL = 0 and CLR = 1 on the same edge with D = 0x7A -> Q = 0x7A, RUNNING = 1. Next edge CLR = 1 alone -> Q = 0, RUNNING = 0, TC = 0.
- Two 8-bit instances cascaded (low BO -> high BI), low loaded 0x02, high loaded 0x01, both MODE = 1, reload 0xFF -> high decrements only on the edges where low is at 0 with BI = 1.
- With SYNDCNT_SNAPSHOT_EN, load 0x10, BI = 1, SNAP pulsed on the 3rd counting edge -> QS = 0x0E; QS holds while Q continues down.

Source files
------------

// File: rtl/syn_down_cnt.sv
`default_nettype none
// ============================================================================
// Module   : syn_down_cnt
// Brief    : Synchronous load/clear down-counter with borrow chain, reload
//            register and one-shot/periodic run state machine. BO cascades
//            into the BI of further instances.
//            Optional macro SYNDCNT_SNAPSHOT_EN adds SNAP input and QS
//            snapshot output.
// Revision : 1.0 - initial release
// ============================================================================
module syn_down_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] D,
   input  logic             LDL,
   input  logic             WRRL,
   input  logic             CLR,
   input  logic             BI,
   input  logic             MODE,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] QB,
   output logic             BO,
   output logic             TC,
   output logic             RUNNING
`ifdef SYNDCNT_SNAPSHOT_EN
   ,
   input  logic             SNAP,
   output logic [WIDTH-1:0] QS
`endif
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] qb_q, qb_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;
   logic             w_zero;

   assign w_zero = (cnt_q == '0);

   // Next-state and next-count: load beats clear beats counting.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tc_d     = 1'b0;
      reload_d = WRRL ? D : reload_q;
      if (!LDL) begin
         cnt_d   = D;
         state_d = ST_RUN;
      end else if (CLR) begin
         cnt_d   = '0;
         state_d = ST_IDLE;
      end else if ((state_q == ST_RUN) && BI) begin
         if (!w_zero) begin
            cnt_d = cnt_q - WIDTH'(1);
         end else begin
            // Terminal count: the reload value is the one held before any
            // same-edge WRRL, so reload_q (not reload_d) is used here.
            tc_d = 1'b1;
            if (MODE) begin
               cnt_d = reload_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
      end
      qb_d = ~cnt_d;
   end

   // State, counter, inverse copy, reload register and TC pulse registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         qb_q     <= '1;
         reload_q <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         qb_q     <= qb_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   assign Q       = cnt_q;
   assign QB      = qb_q;
   assign TC      = tc_q;
   assign RUNNING = (state_q == ST_RUN);
   assign BO      = BI & (state_q == ST_RUN) & w_zero;

`ifdef SYNDCNT_SNAPSHOT_EN
   logic [WIDTH-1:0] qs_q, qs_d;

   // Snapshot captures the pre-update count of the edge on which SNAP is high.
   always_comb begin
      qs_d = qs_q;
      if (SNAP) begin
         qs_d = cnt_q;
      end
   end

   // Snapshot register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         qs_q <= '0;
      end else begin
         qs_q <= qs_d;
      end
   end

   assign QS = qs_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_syn_down_cnt.sv
`default_nettype none
// ============================================================================
// Module   : tb_syn_down_cnt
// Brief    : Scoreboard bench for syn_down_cnt (8-bit), including a two-stage
//            cascade. Snapshot checks compile in with SYNDCNT_SNAPSHOT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_syn_down_cnt;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] D;
   logic       LDL, WRRL, CLR, BI, MODE, SNAP;
   logic [7:0] Q, QB;
   logic       BO, TC, RUNNING;
   logic [7:0] hd;
   logic       hldl, hwrrl, hclr, hmode;
   logic [7:0] hq, hqb;
   logic       hbo, htc, hrun;
`ifdef SYNDCNT_SNAPSHOT_EN
   logic [7:0] QS, hqs;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] q;
      logic       run;
      logic       tc;
      logic       bo;
      logic [7:0] hq;
      logic [7:0] qs;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] exp_qs = 8'h00;

   always #5 CLK = ~CLK;

   syn_down_cnt #(.WIDTH(8)) u_dut (
      .CLK(CLK), .RESET(RESET), .D(D), .LDL(LDL), .WRRL(WRRL), .CLR(CLR),
      .BI(BI), .MODE(MODE), .Q(Q), .QB(QB), .BO(BO), .TC(TC), .RUNNING(RUNNING)
`ifdef SYNDCNT_SNAPSHOT_EN
      , .SNAP(SNAP), .QS(QS)
`endif
   );

   syn_down_cnt #(.WIDTH(8)) u_hi (
      .CLK(CLK), .RESET(RESET), .D(hd), .LDL(hldl), .WRRL(hwrrl), .CLR(hclr),
      .BI(BO), .MODE(hmode), .Q(hq), .QB(hqb), .BO(hbo), .TC(htc), .RUNNING(hrun)
`ifdef SYNDCNT_SNAPSHOT_EN
      , .SNAP(1'b0), .QS(hqs)
`endif
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Push the expected state after the next edge, then advance to edge+2.
   task automatic expect_next(input logic [7:0] q, input logic run, input logic tc,
                              input logic bo, input logic [7:0] h);
      exp_t e;
      e.q = q; e.run = run; e.tc = tc; e.bo = bo; e.hq = h; e.qs = exp_qs;
      sb.push_back(e);
      @(posedge CLK);
      #2;
   endtask

   // Monitor: every edge with a pending expectation, compare 1 time unit later.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q",       {8'h0, Q},       {8'h0, e.q});
            check("qb",      {8'h0, QB},      {8'h0, ~e.q});
            check("running", {15'h0, RUNNING}, {15'h0, e.run});
            check("tc",      {15'h0, TC},      {15'h0, e.tc});
            check("bo",      {15'h0, BO},      {15'h0, e.bo});
            check("hi_q",    {8'h0, hq},      {8'h0, e.hq});
`ifdef SYNDCNT_SNAPSHOT_EN
            check("qs",      {8'h0, QS},      {8'h0, e.qs});
`endif
         end
      end
   end

   initial begin
      RESET = 1'b1; D = 8'h00; LDL = 1'b1; WRRL = 1'b0; CLR = 1'b0;
      BI = 1'b0; MODE = 1'b0; SNAP = 1'b0;
      hd = 8'h00; hldl = 1'b1; hwrrl = 1'b0; hclr = 1'b0; hmode = 1'b0;
      repeat (2) @(posedge CLK);
      #2;
      RESET = 1'b0;
      @(posedge CLK);
      #2;

      // Asynchronous reset mid-cycle, then IDLE ignores BI
      LDL = 1'b0; D = 8'h55;
      expect_next(8'h55, 1, 0, 0, 8'h00);
      LDL = 1'b1;
      #2 RESET = 1'b1;
      #1;
      check("rst_q",   {8'h0, Q},        16'h0000);
      check("rst_qb",  {8'h0, QB},       16'h00FF);
      check("rst_tc",  {15'h0, TC},      16'h0000);
      check("rst_run", {15'h0, RUNNING}, 16'h0000);
      #1 RESET = 1'b0;
      BI = 1'b1;
      expect_next(8'h00, 0, 0, 0, 8'h00);

      // One-shot countdown from 3
      LDL = 1'b0; D = 8'h03; MODE = 1'b0;
      expect_next(8'h03, 1, 0, 0, 8'h00);
      LDL = 1'b1;
      expect_next(8'h02, 1, 0, 0, 8'h00);
      expect_next(8'h01, 1, 0, 0, 8'h00);
      expect_next(8'h00, 1, 0, 1, 8'h00);
      expect_next(8'h00, 0, 1, 0, 8'h00);
      expect_next(8'h00, 0, 0, 0, 8'h00);

      // Periodic mode with reload 5, then WRRL on a terminal edge
      BI = 1'b0; WRRL = 1'b1; D = 8'h05;
      expect_next(8'h00, 0, 0, 0, 8'h00);
      WRRL = 1'b0; LDL = 1'b0; D = 8'h01; MODE = 1'b1; BI = 1'b1;
      expect_next(8'h01, 1, 0, 0, 8'h00);
      LDL = 1'b1;
      expect_next(8'h00, 1, 0, 1, 8'h00);
      expect_next(8'h05, 1, 1, 0, 8'h00);
      for (int v = 4; v >= 1; v--) expect_next(8'(v), 1, 0, 0, 8'h00);
      expect_next(8'h00, 1, 0, 1, 8'h00);
      WRRL = 1'b1; D = 8'h09;
      expect_next(8'h05, 1, 1, 0, 8'h00);
      WRRL = 1'b0;
      for (int v = 4; v >= 1; v--) expect_next(8'(v), 1, 0, 0, 8'h00);
      expect_next(8'h00, 1, 0, 1, 8'h00);
      expect_next(8'h09, 1, 1, 0, 8'h00);

      // Load beats clear, then clear alone
      BI = 1'b0; LDL = 1'b0; CLR = 1'b1; D = 8'h7A;
      expect_next(8'h7A, 1, 0, 0, 8'h00);
      LDL = 1'b1;
      expect_next(8'h00, 0, 0, 0, 8'h00);
      CLR = 1'b0;

      // Load of zero: immediate terminal count on next BI edge
      LDL = 1'b0; D = 8'h00; MODE = 1'b0; BI = 1'b1;
      expect_next(8'h00, 1, 0, 1, 8'h00);
      LDL = 1'b1;
      expect_next(8'h00, 0, 1, 0, 8'h00);

      // Clear on a terminal edge suppresses TC
      LDL = 1'b0; D = 8'h01;
      expect_next(8'h01, 1, 0, 0, 8'h00);
      LDL = 1'b1;
      expect_next(8'h00, 1, 0, 1, 8'h00);
      CLR = 1'b1;
      expect_next(8'h00, 0, 0, 0, 8'h00);
      CLR = 1'b0;

      // Cascade: low BO drives high BI
      BI = 1'b0; WRRL = 1'b1; D = 8'hFF; hwrrl = 1'b1; hd = 8'hFF;
      expect_next(8'h00, 0, 0, 0, 8'h00);
      WRRL = 1'b0; hwrrl = 1'b0;
      LDL = 1'b0; D = 8'h02; hldl = 1'b0; hd = 8'h01; MODE = 1'b1; hmode = 1'b1; BI = 1'b1;
      expect_next(8'h02, 1, 0, 0, 8'h01);
      LDL = 1'b1; hldl = 1'b1;
      expect_next(8'h01, 1, 0, 0, 8'h01);
      expect_next(8'h00, 1, 0, 1, 8'h01);
      expect_next(8'hFF, 1, 1, 0, 8'h00);
      expect_next(8'hFE, 1, 0, 0, 8'h00);
      expect_next(8'hFD, 1, 0, 0, 8'h00);

      // Snapshot of the pre-update count on the 3rd counting edge
      CLR = 1'b1; hclr = 1'b1; BI = 1'b0;
      expect_next(8'h00, 0, 0, 0, 8'h00);
      CLR = 1'b0; hclr = 1'b0; LDL = 1'b0; D = 8'h10;
      expect_next(8'h10, 1, 0, 0, 8'h00);
      LDL = 1'b1; BI = 1'b1;
      expect_next(8'h0F, 1, 0, 0, 8'h00);
      expect_next(8'h0E, 1, 0, 0, 8'h00);
      SNAP = 1'b1; exp_qs = 8'h0E;
      expect_next(8'h0D, 1, 0, 0, 8'h00);
      SNAP = 1'b0;
      expect_next(8'h0C, 1, 0, 0, 8'h00);
      expect_next(8'h0B, 1, 0, 0, 8'h00);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
      #2;
      if (sb.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
